// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// alu_ctrl_pkg : opcodes, FSM state encoding and default MUL latency
// Revision     : 1.0
// ============================================================================
package alu_ctrl_pkg;

  typedef logic [2:0] op_t;
  typedef logic [1:0] state_t;

  localparam op_t OP_ADD   = 3'b000;
  localparam op_t OP_SUB   = 3'b001;
  localparam op_t OP_MUL   = 3'b010;
  localparam op_t OP_AND   = 3'b011;
  localparam op_t OP_XOR   = 3'b100;
  localparam op_t OP_SL    = 3'b101;
  localparam op_t OP_SR    = 3'b110;
  localparam op_t OP_WRONG = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned MUL_LAT_DEFAULT = 3;

endpackage
`default_nettype wire

// File: rtl/ALU.sv
`default_nettype none
// ============================================================================
// ALU : shared combinational 32-bit ALU (add/sub/mul/and/xor/shifts)
// Revision : 1.0
// ============================================================================
module ALU
  import alu_ctrl_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  logic        w_big_shift;
  logic [31:0] w_shl;
  logic [31:0] w_sra;

  // Shift amounts of 32 or more saturate instead of wrapping on b[4:0]
  assign w_big_shift = |b_i[31:5];
  assign w_shl       = w_big_shift ? 32'd0 : (a_i << b_i[4:0]);
  assign w_sra       = w_big_shift ? {32{a_i[31]}} : 32'($signed(a_i) >>> b_i[4:0]);

  always_comb begin
    y_o = 32'd0;
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_MUL:  y_o = a_i * b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_SL:   y_o = w_shl;
      OP_SR:   y_o = w_sra;
      default: y_o = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : two-requester round-robin front end for one shared ALU
// Revision    : 1.0
// ============================================================================
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  input  logic        req1_valid_i,
  output logic        req0_ready_o,
  output logic        req1_ready_o,
  input  logic [2:0]  req0_op_i,
  input  logic [2:0]  req1_op_i,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] res_data_o,
  output logic        res_id_o,
  output logic        res_err_o
);

  localparam logic [2:0] C_MUL_CNT_INIT = 3'(MUL_LAT - 1);

  state_t      state_q, state_d;
  logic        rr_q, rr_d;            // 1 = req1 has priority
  logic [2:0]  cnt_q, cnt_d;
  op_t         op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        id_q, id_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_id_q, res_id_d;
  logic        res_err_q, res_err_d;
  logic        w_gnt0, w_gnt1;
  logic [31:0] w_alu_y;

  ALU u_alu (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (w_alu_y)
  );

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    res_err_d  = res_err_q;
    w_gnt0     = 1'b0;
    w_gnt1     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0_valid_i && (!rr_q || !req1_valid_i)) w_gnt0 = 1'b1;
        else if (req1_valid_i)                        w_gnt1 = 1'b1;
        if (w_gnt0 || w_gnt1) begin
          op_d    = w_gnt1 ? req1_op_i : req0_op_i;
          a_d     = w_gnt1 ? req1_a_i  : req0_a_i;
          b_d     = w_gnt1 ? req1_b_i  : req0_b_i;
          id_d    = w_gnt1;
          rr_d    = w_gnt0;
          cnt_d   = (op_d == OP_MUL) ? C_MUL_CNT_INIT : 3'd0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == 3'd0) begin
          res_data_d = (op_q == OP_WRONG) ? 32'd0 : w_alu_y;
          res_err_d  = (op_q == OP_WRONG);
          res_id_d   = id_q;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DONE: begin
        if (res_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      rr_q       <= 1'b0;
      cnt_q      <= 3'd0;
      op_q       <= OP_ADD;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      id_q       <= 1'b0;
      res_data_q <= 32'd0;
      res_id_q   <= 1'b0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
      res_err_q  <= res_err_d;
    end
  end

  assign req0_ready_o = w_gnt0;
  assign req1_ready_o = w_gnt1;
  assign res_valid_o  = (state_q == ST_DONE);
  assign res_data_o   = res_data_q;
  assign res_id_o     = res_id_q;
  assign res_err_o    = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_arbiter : self-checking bench for alu_arbiter
// Revision       : 1.0
// ============================================================================
module tb_alu_arbiter;

  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v1, r0, r1;
  logic [2:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        rvalid, rready, rid, rerr;
  logic [31:0] rdata;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          last_gnt;   // requester granted most recently; 1 after reset favours req0

  alu_arbiter #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req0_valid_i(v0), .req1_valid_i(v1),
    .req0_ready_o(r0), .req1_ready_o(r1),
    .req0_op_i(op0), .req1_op_i(op1),
    .req0_a_i(a0), .req0_b_i(b0), .req1_a_i(a1), .req1_b_i(b1),
    .res_valid_o(rvalid), .res_ready_i(rready),
    .res_data_o(rdata), .res_id_o(rid), .res_err_o(rerr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent behavioural ALU model using 64-bit integer arithmetic
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint r  = 0;
    case (op)
      3'd0: r = sa + sb;
      3'd1: r = sa - sb;
      3'd2: r = sa * sb;
      3'd3: r = longint'({32'd0, a & b});
      3'd4: r = longint'({32'd0, a ^ b});
      3'd5: r = (b >= 32) ? 0 : (ua << b);
      3'd6: r = sa >>> ((b >= 32) ? 63 : b);
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    v0 = 0; v1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    rready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    last_gnt = 1'b1;
  endtask

  task automatic drive(input bit id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id) begin v1 = 1; op1 = op; a1 = a; b1 = b; end
    else    begin v0 = 1; op0 = op; a0 = a; b0 = b; end
  endtask

  // Issue one op on a single requester (valid held until the result), res_ready_i = 1
  task automatic run_op(input bit id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] d, output logic e, output logic ri, output int lat, output bit leak);
    int acc = 0;
    bit got = 0;
    lat = -1; leak = 0; d = 'x; e = 'x; ri = 'x;
    drive(id, op, a, b);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (id ? r1 : r0) begin got = 1; acc = cyc; end
    end
    if (got) begin
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (rvalid) begin got = 1; lat = cyc - acc; d = rdata; e = rerr; ri = rid; end
        else if (r0 | r1) leak = 1;
      end
    end
    @(posedge clk); #1;
    v0 = 0; v1 = 0;
    last_gnt = id;
  endtask

  vec_t tbl[14];
  logic [31:0] d, sd;
  logic        e, ri, se, sid;
  int          lat, wait_n;
  bit          leak, ok, got;

  initial begin
    tbl[0]  = '{0, 3'd0, 32'd5,          32'd7,          32'h0000000C, 1'b0};
    tbl[1]  = '{1, 3'd1, 32'd10,         32'd3,          32'h00000007, 1'b0};
    tbl[2]  = '{0, 3'd2, 32'hFFFFFFFD,   32'd4,          32'hFFFFFFF4, 1'b0};
    tbl[3]  = '{1, 3'd6, 32'h80000000,   32'd4,          32'hF8000000, 1'b0};
    tbl[4]  = '{0, 3'd7, 32'd1234,       32'd5,          32'h00000000, 1'b1};
    tbl[5]  = '{1, 3'd5, 32'd1,          32'd31,         32'h80000000, 1'b0};
    tbl[6]  = '{0, 3'd5, 32'd1,          32'd32,         32'h00000000, 1'b0};
    tbl[7]  = '{1, 3'd6, 32'h80000000,   32'd32,         32'hFFFFFFFF, 1'b0};
    tbl[8]  = '{0, 3'd6, 32'h7FFFFFFF,   32'd40,         32'h00000000, 1'b0};
    tbl[9]  = '{1, 3'd3, 32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000, 1'b0};
    tbl[10] = '{0, 3'd4, 32'h000000F0,   32'h000000FF,   32'h0000000F, 1'b0};
    tbl[11] = '{1, 3'd0, 32'h7FFFFFFF,   32'd1,          32'h80000000, 1'b0};
    tbl[12] = '{0, 3'd2, 32'h00010000,   32'h00010000,   32'h00000000, 1'b0};
    tbl[13] = '{1, 3'd1, 32'd0,          32'd1,          32'hFFFFFFFF, 1'b0};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("reset_valid", {31'd0, rvalid}, 0);
    chk("reset_data",  rdata, 0);
    chk("reset_id",    {31'd0, rid}, 0);
    chk("reset_err",   {31'd0, rerr}, 0);
    chk("reset_ready", {30'd0, r1, r0}, 0);

    // Both valid from reset: req0 first, req1 next
    @(posedge clk); #1;
    drive(0, 3'd1, 32'd10, 32'd3);
    drive(1, 3'd4, 32'hF0, 32'hFF);
    @(negedge clk);
    chk("rr_first_grant", {30'd0, r1, r0}, 32'b01);
    @(posedge clk); #1 v0 = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = rvalid; end
    chk("rr_first_seen", {31'd0, got}, 1);
    chk("rr_first_data", rdata, 7);
    chk("rr_first_id", {31'd0, rid}, 0);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = r1; end
    chk("rr_second_grant", {31'd0, got}, 1);
    @(posedge clk); #1 v1 = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = rvalid; end
    chk("rr_second_seen", {31'd0, got}, 1);
    chk("rr_second_data", rdata, 32'h0F);
    chk("rr_second_id", {31'd0, rid}, 1);
    @(posedge clk); #1;
    last_gnt = 1;

    // Table-driven single-requester ops
    foreach (tbl[k]) begin
      run_op(tbl[k].id, tbl[k].op, tbl[k].a, tbl[k].b, d, e, ri, lat, leak);
      chk($sformatf("tbl%0d_data", k), d, tbl[k].exp);
      chk($sformatf("tbl%0d_err", k), {31'd0, e}, {31'd0, tbl[k].err});
      chk($sformatf("tbl%0d_id", k), {31'd0, ri}, {31'd0, tbl[k].id});
      chk($sformatf("tbl%0d_lat", k), lat, (tbl[k].op == 3'd2) ? MUL_LAT + 1 : 2);
      chk($sformatf("tbl%0d_noready", k), {31'd0, leak}, 0);
    end

    // DONE stall: res_ready_i low 5 cycles, other requester waiting
    rready = 0;
    drive(0, 3'd0, 32'd100, 32'd23);
    @(negedge clk);
    chk("stall_grant", {30'd0, r1, r0}, 32'b01);
    @(posedge clk); #1 drive(1, 3'd0, 32'd1, 32'd1);
    last_gnt = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = rvalid; end
    chk("stall_seen", {31'd0, got}, 1);
    sd = rdata; se = rerr; sid = rid;
    chk("stall_data", sd, 123);
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!rvalid || rdata !== sd || rerr !== se || rid !== sid || r0 || r1) ok = 0;
    end
    chk("stall_stable", {31'd0, ok}, 1);
    @(posedge clk); #1 rready = 1;
    @(negedge clk);
    chk("stall_hs_valid", {31'd0, rvalid}, 1);
    chk("stall_hs_nogrant", {30'd0, r1, r0}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_idle_valid", {31'd0, rvalid}, 0);
    chk("stall_idle_grant", {30'd0, r1, r0}, 32'b10);
    #1 v0 = 0; v1 = 0;

    // Reset during MUL EXEC after a req0 grant (pointer then favours req1)
    @(posedge clk); #1;
    drive(0, 3'd2, 32'd6, 32'd7);
    @(negedge clk);
    chk("rst_mul_grant", {30'd0, r1, r0}, 32'b01);
    @(posedge clk); #1 v0 = 0; rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    last_gnt = 1;
    @(negedge clk);
    chk("rst_mul_data", rdata, 0);
    ok = 1;
    for (int i = 0; i < MUL_LAT + 3; i++) begin
      if (rvalid) ok = 0;
      @(negedge clk);
    end
    chk("rst_mul_no_result", {31'd0, ok}, 1);
    drive(0, 3'd0, 0, 0);
    drive(1, 3'd0, 0, 0);
    #1;
    chk("rst_mul_ptr_req0", {30'd0, r1, r0}, 32'b01);
    v0 = 0; v1 = 0;

    // Randomised traffic against the reference model
    for (int t = 0; t < 60; t++) begin
      logic [2:0]  rop[2];
      logic [31:0] ra[2], rb[2];
      bit          rv[2];
      bit          eg;
      int          acc;
      bit          first;
      @(posedge clk); #1;
      for (int j = 0; j < 2; j++) begin
        rop[j] = 3'($urandom_range(0, 7));
        ra[j]  = $urandom;
        rb[j]  = (rop[j] == 3'd5 || rop[j] == 3'd6) ? 32'($urandom_range(0, 40)) : $urandom;
        rv[j]  = 1'($urandom_range(0, 1));
      end
      if (!rv[0] && !rv[1]) rv[$urandom_range(0, 1)] = 1;
      eg = (rv[0] && rv[1]) ? !last_gnt : rv[1];
      if (rv[0]) drive(0, rop[0], ra[0], rb[0]);
      if (rv[1]) drive(1, rop[1], ra[1], rb[1]);
      @(negedge clk);
      chk($sformatf("rnd%0d_grant", t), {30'd0, r1, r0}, eg ? 32'b10 : 32'b01);
      acc = cyc;
      @(posedge clk); #1 v0 = 0; v1 = 0;
      last_gnt = eg;
      got = 0; first = 1; wait_n = 0;
      while (!got && wait_n < 60) begin
        rready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        wait_n++;
        if (rvalid && first) begin
          first = 0;
          chk($sformatf("rnd%0d_lat", t), cyc - acc, (rop[eg] == 3'd2) ? MUL_LAT + 1 : 2);
          chk($sformatf("rnd%0d_data", t), rdata, ref_alu(rop[eg], ra[eg], rb[eg]));
          chk($sformatf("rnd%0d_err", t), {31'd0, rerr}, {31'd0, rop[eg] == 3'd7});
          chk($sformatf("rnd%0d_id", t), {31'd0, rid}, {31'd0, eg});
        end
        if (rvalid && rready) got = 1;
        @(posedge clk); #1;
      end
      if (!got) chk($sformatf("rnd%0d_timeout", t), 0, 1);
      rready = 1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
